mem_arbiter: RTL and testbench

- Arbitrates the single-ported main memory between three requesters: the MEM-stage data port (D), the instruction-fetch miss port (I) and the sprite/display read port (S).
- Fixed priority D > I > S, with an anti-starvation override that forces an S grant.
- Sequences one memory transaction at a time and generates the pipeline stall for the CPU.
- Sits between the CPU pipeline / sprite unit and the memory controller.

---
 rtl/mem_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-ported main memory between three read/write masters:
//   D - MEM-stage data port (read or write)
//   I - instruction-fetch miss port (read only)
//   S - sprite/display fetch port (read only)
//
// Arbitration is fixed priority D > I > S. A saturating counter tracks how
// often S has lost while requesting. Once the count reaches SPR_MAX_SKIP,
// S wins the next arbitration unconditionally. One memory transaction runs
// at a time (IDLE -> BUSY -> RESP). The owner receives a single-cycle ack in
// RESP, so no two acks are ever asserted together.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   d_req/d_we/d_addr/d_wdata      data port request; d_ack completion pulse
//   i_req/i_addr                   instruction read request; i_ack pulse
//   s_req/s_addr                   sprite read request; s_ack pulse
//   rdata                          read data, valid in the ack cycle of a read
//   err                            with the ack when the transaction timed out
//   mem_re/mem_we/mem_addr/
//   mem_wdata                      registered memory command, held in BUSY
//   mem_rdata/mem_rdy              memory read data and completion strobe
//   cpu_stall                      CPU pipeline stall (D or I outstanding)
//   busy                           a transaction is in BUSY or RESP
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned SPR_MAX_SKIP = 4,   // 1..15
    parameter int unsigned TIMEOUT      = 255  // 0 disables the timeout
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [21:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,

    input  logic        i_req,
    input  logic [21:0] i_addr,
    output logic        i_ack,

    input  logic        s_req,
    input  logic [21:0] s_addr,
    output logic        s_ack,

    output logic [31:0] rdata,
    output logic        err,

    output logic        mem_re,
    output logic        mem_we,
    output logic [21:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy,

    output logic        cpu_stall,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_D = 2'd0,
        OWN_I = 2'd1,
        OWN_S = 2'd2
    } owner_t;

    // Timeout counter only has to reach TIMEOUT-1.
    localparam int unsigned  TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam bit            TMO_EN    = (TIMEOUT != 0);
    localparam logic [3:0]    SKIP_LIMIT = 4'(SPR_MAX_SKIP);
    localparam logic [3:0]    SKIP_SAT   = 4'd15;

    state_t        state_q, state_d;
    owner_t        owner_q;
    logic [3:0]    skip_cnt_q;
    logic [TW-1:0] tcnt_q;
    logic          err_flag_q;

    logic          grant_valid;
    owner_t        grant_owner;
    logic          tmo_hit;

    // -------------------------------------------------------------------------
    // Arbitration (only meaningful in IDLE)
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default on entry so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_owner = OWN_D;
        if (state_q == ST_IDLE) begin
            if (s_req && (skip_cnt_q >= SKIP_LIMIT)) begin
                // Starvation override: S has lost often enough.
                grant_valid = 1'b1;
                grant_owner = OWN_S;
            end else if (d_req) begin
                grant_valid = 1'b1;
                grant_owner = OWN_D;
            end else if (i_req) begin
                grant_valid = 1'b1;
                grant_owner = OWN_I;
            end else if (s_req) begin
                grant_valid = 1'b1;
                grant_owner = OWN_S;
            end
        end
    end

    // Last BUSY cycle allowed without mem_rdy; BUSY lasts at most TIMEOUT cycles.
    assign tmo_hit = TMO_EN && !mem_rdy && (tcnt_q == TMO_LAST);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_rdy || tmo_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: owner, command registers, read data, counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_D;
            skip_cnt_q <= '0;
            tcnt_q     <= '0;
            err_flag_q <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tcnt_q     <= '0;
                    err_flag_q <= 1'b0;
                    if (grant_valid) begin
                        owner_q   <= grant_owner;
                        mem_wdata <= d_wdata;
                        case (grant_owner)
                            OWN_D: begin
                                mem_addr <= d_addr;
                                mem_we   <= d_we;
                                mem_re   <= !d_we;
                            end
                            OWN_I: begin
                                mem_addr <= i_addr;
                                mem_we   <= 1'b0;
                                mem_re   <= 1'b1;
                            end
                            default: begin
                                mem_addr <= s_addr;
                                mem_we   <= 1'b0;
                                mem_re   <= 1'b1;
                            end
                        endcase

                        // S losing while it is waiting counts as a skip.
                        if (grant_owner == OWN_S) begin
                            skip_cnt_q <= '0;
                        end else if (s_req && (skip_cnt_q != SKIP_SAT)) begin
                            skip_cnt_q <= skip_cnt_q + 4'd1;
                        end
                    end
                end

                ST_BUSY: begin
                    tcnt_q <= tcnt_q + TW'(1);
                    if (mem_rdy) begin
                        // Writes leave the previous read data visible.
                        if (mem_re) begin
                            rdata <= mem_rdata;
                        end
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                    end else if (tmo_hit) begin
                        mem_re     <= 1'b0;
                        mem_we     <= 1'b0;
                        err_flag_q <= 1'b1;
                    end
                end

                default: begin
                    // RESP: the ack is presented combinationally this cycle.
                    tcnt_q     <= '0;
                    err_flag_q <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output logic
    // -------------------------------------------------------------------------
    always_comb begin
        d_ack = 1'b0;
        i_ack = 1'b0;
        s_ack = 1'b0;
        err   = 1'b0;
        busy  = (state_q != ST_IDLE);
        if (state_q == ST_RESP) begin
            err = err_flag_q;
            case (owner_q)
                OWN_D:   d_ack = 1'b1;
                OWN_I:   i_ack = 1'b1;
                default: s_ack = 1'b1;
            endcase
        end
    end

    assign cpu_stall = (d_req & ~d_ack) | (i_req & ~i_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter (SPR_MAX_SKIP = 2, TIMEOUT = 8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. "Cycle 0" is the cycle in which a request is first driven.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int SKIP = 2;
    localparam int TMO  = 8;

    logic        clk;
    logic        rst_n;
    logic        d_req, d_we, i_req, s_req;
    logic [21:0] d_addr, i_addr, s_addr;
    logic [31:0] d_wdata;
    logic        d_ack, i_ack, s_ack;
    logic [31:0] rdata;
    logic        err;
    logic        mem_re, mem_we;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rdy;
    logic        cpu_stall, busy;

    int n_pass  = 0;
    int n_total = 0;

    mem_arbiter #(
        .SPR_MAX_SKIP(SKIP),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .s_req    (s_req),
        .s_addr   (s_addr),
        .s_ack    (s_ack),
        .rdata    (rdata),
        .err      (err),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rdy  (mem_rdy),
        .cpu_stall(cpu_stall),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog expired");
    end

    // D-port vector: inputs for one cycle and the outputs expected in it.
    typedef struct {
        logic        d_req;
        logic        d_we;
        logic [21:0] d_addr;
        logic [31:0] d_wdata;
        logic        rdy;
        logic [31:0] mrd;
        logic        e_re;
        logic        e_we;
        logic [21:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_ack;
        logic [31:0] e_rdata;
        logic        e_stall;
        logic        e_busy;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t row(
        input logic dr, input logic dw, input logic [21:0] da, input logic [31:0] dd,
        input logic rdy, input logic [31:0] mrd,
        input logic ere, input logic ewe, input logic [21:0] ea, input logic [31:0] ewd,
        input logic eack, input logic [31:0] erd, input logic estall, input logic ebusy);
        vec_t v;
        v.d_req = dr;   v.d_we = dw;    v.d_addr = da;  v.d_wdata = dd;
        v.rdy = rdy;    v.mrd = mrd;
        v.e_re = ere;   v.e_we = ewe;   v.e_addr = ea;  v.e_wdata = ewd;
        v.e_ack = eack; v.e_rdata = erd; v.e_stall = estall; v.e_busy = ebusy;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        i_req = 1'b0; i_addr = '0;
        s_req = 1'b0; s_addr = '0;
        mem_rdy = 1'b0; mem_rdata = '0;
    endtask

    // Leaves the bench 1 unit after a rising edge with reset released.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_d_ack"},     d_ack,     0);
        check({tag, "_i_ack"},     i_ack,     0);
        check({tag, "_s_ack"},     s_ack,     0);
        check({tag, "_err"},       err,       0);
        check({tag, "_mem_re"},    mem_re,    0);
        check({tag, "_mem_we"},    mem_we,    0);
        check({tag, "_mem_addr"},  mem_addr,  0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_rdata"},     rdata,     0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_cpu_stall"}, cpu_stall, 0);
    endtask

    // -------------------------------------------------------------------------
    // Randomized traffic against a transaction-level reference model.
    // -------------------------------------------------------------------------
    task automatic run_random(input int n_cycles);
        bit          rq [3];
        bit          ack_seen [3];
        logic [21:0] ra [3];
        logic        rwe;
        logic [31:0] rwd;
        int          skip_m;
        logic [31:0] rdata_m;
        bit          act;
        int          own;
        bit          wr;
        logic [21:0] a;
        logic [31:0] wd;
        bit          terr;
        logic [31:0] rv;
        int          cmd_c, rdy_c, ack_c, dly;
        bit          in_busy;
        bit          e_ack [3];

        for (int r = 0; r < 3; r++) begin
            rq[r] = 0; ack_seen[r] = 0; ra[r] = '0;
        end
        rwe = 0; rwd = '0; skip_m = 0; rdata_m = '0; act = 0;
        own = 0; wr = 0; a = '0; wd = '0; terr = 0; rv = '0;
        cmd_c = 0; rdy_c = 0; ack_c = 0;

        for (int cyc = 0; cyc < n_cycles; cyc++) begin
            // Requesters: hold until acked, then re-request or go quiet.
            for (int r = 0; r < 3; r++) begin
                bit fresh;
                fresh = 0;
                if (rq[r] && ack_seen[r]) begin
                    ack_seen[r] = 0;
                    rq[r] = ($urandom_range(1) == 1);
                    fresh = rq[r];
                end else if (!rq[r] && ($urandom_range(3) == 0)) begin
                    rq[r] = 1;
                    fresh = 1;
                end
                if (fresh) begin
                    ra[r] = 22'($urandom);
                    if (r == 0) begin
                        rwe = ($urandom_range(1) == 1);
                        rwd = $urandom;
                    end
                end
            end
            d_req = rq[0]; d_addr = ra[0]; d_we = rwe; d_wdata = rwd;
            i_req = rq[1]; i_addr = ra[1];
            s_req = rq[2]; s_addr = ra[2];

            // One transaction at a time; arbitration resumes after its ack.
            if (act && cyc > ack_c) act = 0;
            if (!act && (rq[0] || rq[1] || rq[2])) begin
                if (rq[2] && skip_m >= SKIP) own = 2;
                else if (rq[0])               own = 0;
                else if (rq[1])               own = 1;
                else                          own = 2;
                if (own == 2)                   skip_m = 0;
                else if (rq[2] && skip_m < 15)  skip_m++;
                wr    = (own == 0) && rwe;
                a     = ra[own];
                wd    = rwd;
                cmd_c = cyc + 1;
                dly   = $urandom_range(9, 0);
                if (dly < TMO) begin
                    terr  = 0;
                    rdy_c = cmd_c + dly;
                    ack_c = rdy_c + 1;
                end else begin
                    terr  = 1;
                    rdy_c = -1;
                    ack_c = cmd_c + TMO;
                end
                rv  = $urandom;
                act = 1;
            end

            // Memory: answers on schedule; stray strobes outside BUSY.
            in_busy = act && (cyc >= cmd_c) && (cyc < ack_c);
            if (act && !terr && cyc == rdy_c) begin
                mem_rdy = 1'b1; mem_rdata = rv;
            end else if (!in_busy && ($urandom_range(3) == 0)) begin
                mem_rdy = 1'b1; mem_rdata = $urandom;
            end else begin
                mem_rdy = 1'b0; mem_rdata = $urandom;
            end

            @(negedge clk);
            for (int r = 0; r < 3; r++) begin
                e_ack[r] = act && (cyc == ack_c) && (own == r);
                if (e_ack[r]) ack_seen[r] = 1;
            end
            if (act && cyc == ack_c && !wr && !terr) rdata_m = rv;

            check("rnd_d_ack", d_ack, e_ack[0]);
            check("rnd_i_ack", i_ack, e_ack[1]);
            check("rnd_s_ack", s_ack, e_ack[2]);
            check("rnd_err",   err,   act && (cyc == ack_c) && terr);
            check("rnd_busy",  busy,  act && (cyc >= cmd_c) && (cyc <= ack_c));
            check("rnd_mem_re", mem_re, in_busy && !wr);
            check("rnd_mem_we", mem_we, in_busy && wr);
            check("rnd_rdata", rdata, rdata_m);
            check("rnd_cpu_stall", cpu_stall,
                  (rq[0] && !e_ack[0]) || (rq[1] && !e_ack[1]));
            if (in_busy) begin
                check("rnd_mem_addr", mem_addr, a);
                if (wr) check("rnd_mem_wdata", mem_wdata, wd);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        int order_tbl [3];
        order_tbl = '{0, 0, 2};

        // Reset state, sampled while reset is held.
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        do_reset();

        // D read then D write, cycle by cycle.
        //          d_req we addr       wdata          rdy mem_rdata      re we e_addr     e_wdata        ack e_rdata        stall busy
        tbl[0]  = row(1, 0, 22'h00010, 32'h0,        0, 32'h0,        0, 0, 22'h0,      32'h0,        0, 32'h0,        1, 0);
        tbl[1]  = row(1, 0, 22'h00010, 32'h0,        0, 32'h0,        1, 0, 22'h00010,  32'h0,        0, 32'h0,        1, 1);
        tbl[2]  = row(1, 0, 22'h00010, 32'h0,        0, 32'h0,        1, 0, 22'h00010,  32'h0,        0, 32'h0,        1, 1);
        tbl[3]  = row(1, 0, 22'h00010, 32'h0,        0, 32'h0,        1, 0, 22'h00010,  32'h0,        0, 32'h0,        1, 1);
        tbl[4]  = row(1, 0, 22'h00010, 32'h0,        1, 32'hDEADBEEF, 1, 0, 22'h00010,  32'h0,        0, 32'h0,        1, 1);
        tbl[5]  = row(1, 0, 22'h00010, 32'h0,        0, 32'h0,        0, 0, 22'h00010,  32'h0,        1, 32'hDEADBEEF, 0, 1);
        tbl[6]  = row(0, 0, 22'h0,     32'h0,        1, 32'h55555555, 0, 0, 22'h00010,  32'h0,        0, 32'hDEADBEEF, 0, 0);
        tbl[7]  = row(1, 1, 22'h3FFFFF, 32'h12345678, 0, 32'h0,       0, 0, 22'h00010,  32'h0,        0, 32'hDEADBEEF, 1, 0);
        tbl[8]  = row(1, 1, 22'h3FFFFF, 32'h12345678, 0, 32'h0,       0, 1, 22'h3FFFFF, 32'h12345678, 0, 32'hDEADBEEF, 1, 1);
        tbl[9]  = row(1, 1, 22'h3FFFFF, 32'h12345678, 1, 32'hCAFEF00D, 0, 1, 22'h3FFFFF, 32'h12345678, 0, 32'hDEADBEEF, 1, 1);
        tbl[10] = row(1, 1, 22'h3FFFFF, 32'h12345678, 0, 32'h0,       0, 0, 22'h3FFFFF, 32'h12345678, 1, 32'hDEADBEEF, 0, 1);
        tbl[11] = row(0, 0, 22'h0,     32'h0,        0, 32'h0,        0, 0, 22'h3FFFFF, 32'h12345678, 0, 32'hDEADBEEF, 0, 0);

        for (int i = 0; i < 12; i++) begin
            d_req = tbl[i].d_req;  d_we = tbl[i].d_we;
            d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
            mem_rdy = tbl[i].rdy;  mem_rdata = tbl[i].mrd;
            @(negedge clk);
            check($sformatf("tbl%0d_mem_re", i),    mem_re,    tbl[i].e_re);
            check($sformatf("tbl%0d_mem_we", i),    mem_we,    tbl[i].e_we);
            check($sformatf("tbl%0d_mem_addr", i),  mem_addr,  tbl[i].e_addr);
            check($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].e_wdata);
            check($sformatf("tbl%0d_d_ack", i),     d_ack,     tbl[i].e_ack);
            check($sformatf("tbl%0d_rdata", i),     rdata,     tbl[i].e_rdata);
            check($sformatf("tbl%0d_cpu_stall", i), cpu_stall, tbl[i].e_stall);
            check($sformatf("tbl%0d_busy", i),      busy,      tbl[i].e_busy);
            next_cycle();
        end
        clear_inputs();

        // I read with no mem_rdy: 8 BUSY cycles, then i_ack with err.
        i_req = 1'b1; i_addr = 22'h2AAAA;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) i_req = 1'b0;
            @(negedge clk);
            check($sformatf("tmo%0d_mem_re", c), mem_re, (c >= 1) && (c <= 8));
            check($sformatf("tmo%0d_i_ack", c),  i_ack,  c == 9);
            check($sformatf("tmo%0d_err", c),    err,    c == 9);
            check($sformatf("tmo%0d_busy", c),   busy,   (c >= 1) && (c <= 9));
            check($sformatf("tmo%0d_stall", c),  cpu_stall, c <= 8);
            if (c >= 1 && c <= 8) check($sformatf("tmo%0d_mem_addr", c), mem_addr, 22'h2AAAA);
            if (c == 9) check("tmo_rdata_kept", rdata, 32'hDEADBEEF);
            next_cycle();
        end

        // All three hold requests; memory answers one cycle into BUSY.
        // With the starvation limit at 2 the grant order is D, D, S repeating.
        do_reset();
        d_req = 1'b1; d_addr = 22'h00111;
        i_req = 1'b1; i_addr = 22'h00222;
        s_req = 1'b1; s_addr = 22'h00333;
        for (int c = 0; c < 36; c++) begin
            int k;
            int ph;
            int eo;
            logic [21:0] ea;
            k  = c / 4;
            ph = c % 4;
            eo = order_tbl[k % 3];
            ea = (eo == 0) ? 22'h00111 : 22'h00333;
            mem_rdy   = (ph == 2);
            mem_rdata = 32'hA0000000 + 32'(k);
            @(negedge clk);
            check($sformatf("fair%0d_d_ack", c), d_ack, (ph == 3) && (eo == 0));
            check($sformatf("fair%0d_i_ack", c), i_ack, 0);
            check($sformatf("fair%0d_s_ack", c), s_ack, (ph == 3) && (eo == 2));
            if (ph == 1) check($sformatf("fair%0d_mem_addr", c), mem_addr, ea);
            if (ph == 3) check($sformatf("fair%0d_rdata", c), rdata, 32'hA0000000 + 32'(k));
            next_cycle();
        end
        clear_inputs();

        // Reset two cycles into an S transaction; a late mem_rdy is ignored.
        do_reset();
        s_req = 1'b1; s_addr = 22'h00155;
        @(negedge clk);
        check("abort_c0_busy", busy, 0);
        next_cycle();
        @(negedge clk);
        check("abort_c1_mem_re", mem_re, 1);
        check("abort_c1_mem_addr", mem_addr, 22'h00155);
        next_cycle();
        rst_n = 1'b0;
        s_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mem_rdy   = (c < 2);
            mem_rdata = 32'h99999999;
            @(negedge clk);
            check($sformatf("abort_after%0d_s_ack", c), s_ack, 0);
            check($sformatf("abort_after%0d_busy", c), busy, 0);
            check($sformatf("abort_after%0d_rdata", c), rdata, 0);
            check($sformatf("abort_after%0d_mem_re", c), mem_re, 0);
            next_cycle();
        end
        clear_inputs();

        // Reset must also clear the skip count: build it to 2 with two D wins
        // over a waiting S, reset mid-transaction, then D must win again.
        do_reset();
        d_req = 1'b1; d_addr = 22'h000AA;
        s_req = 1'b1; s_addr = 22'h000BB;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) d_addr = 22'h000CC;
            mem_rdy = (c == 2);
            @(negedge clk);
            if (c == 1) check("skiprst_c1_mem_addr", mem_addr, 22'h000AA);
            if (c == 3) check("skiprst_c3_d_ack", d_ack, 1);
            if (c == 5) check("skiprst_c5_mem_addr", mem_addr, 22'h000CC);
            next_cycle();
        end
        rst_n = 1'b0;
        d_req = 1'b0; s_req = 1'b0; mem_rdy = 1'b0;
        @(negedge clk);
        check("skiprst_rst_busy", busy, 0);
        next_cycle();
        rst_n = 1'b1;
        d_req = 1'b1; d_addr = 22'h000DD;
        s_req = 1'b1;
        next_cycle();
        @(negedge clk);
        check("skiprst_regrant_mem_addr", mem_addr, 22'h000DD);
        check("skiprst_regrant_mem_re", mem_re, 1);
        next_cycle();
        clear_inputs();

        // Randomized traffic.
        do_reset();
        run_random(1500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
